// File: rtl/contador_mod6_if.sv
// Control/status bundle for the mod-6 tens-of-seconds digit.
// master drives preset and run controls; slave returns count and borrow.
interface contador_mod6_if;
  logic [2:0] data;
  logic       load;
  logic       stop;
  logic [2:0] count;
  logic       tc;

  modport master (
    output data,
    output load,
    output stop,
    input  count,
    input  tc
  );

  modport slave (
    input  data,
    input  load,
    input  stop,
    output count,
    output tc
  );
endinterface

// File: rtl/contador_mod6.sv
// Mod-6 down-counter (5..0) for the timer tens-of-seconds digit.
// CONTADOR_MOD6_STOP_AT_ZERO_EN: saturate at 0 instead of wrapping.
module contador_mod6 (
  input  logic           clk,
  input  logic           reset,
  contador_mod6_if.slave bus
);

  logic [2:0] count_q;
  logic [2:0] load_val;
  logic [2:0] dec_val;
  logic       at_zero;

  assign at_zero = (count_q == 3'd0);

  // presets above 5 clamp so the register never holds 6 or 7
  assign load_val = (bus.data > 3'd5) ? 3'd5 : bus.data;

`ifdef CONTADOR_MOD6_STOP_AT_ZERO_EN
  assign dec_val = at_zero ? 3'd0 : count_q - 3'd1;
`else
  assign dec_val = at_zero ? 3'd5 : count_q - 3'd1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 3'd0;
    end else if (bus.load) begin
      count_q <= load_val;
    end else if (bus.stop) begin
      count_q <= dec_val;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = at_zero & bus.stop & ~bus.load;

endmodule

// File: tb/tb_contador_mod6.sv
// Directed bench for contador_mod6, both wrap and saturate builds.
// Inputs change just after rising edges; outputs sampled there too.
module tb_contador_mod6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  contador_mod6_if ifc ();

  contador_mod6 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [2:0] got,
    input logic [2:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_tc(input string tag, input logic exp);
    check(tag, {2'b00, ifc.tc}, {2'b00, exp});
  endtask

`ifdef CONTADOR_MOD6_STOP_AT_ZERO_EN
  int rel_seq[3]  = '{0, 0, 0};
  int run_seq[13] = '{0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0};
  int sat_seq[5]  = '{1, 0, 0, 0, 0};
  int sat_tc[5]   = '{0, 1, 1, 1, 1};
`else
  int rel_seq[3]  = '{5, 4, 3};
  int run_seq[13] = '{5, 4, 3, 2, 1, 0, 5,
                      4, 3, 2, 1, 0, 5};
  int sat_seq[5]  = '{1, 0, 5, 4, 3};
  int sat_tc[5]   = '{0, 1, 0, 0, 0};
`endif

  initial begin
    reset    = 1'b1;
    ifc.data = 3'd0;
    ifc.load = 1'b0;
    ifc.stop = 1'b0;
    #12;
    check("rst_count", ifc.count, 3'd0);
    chk_tc("rst_tc_stop0", 1'b0);
    ifc.stop = 1'b1;
    #1;
    chk_tc("rst_tc_stop1", 1'b1);

    // async reset between edges
    reset    = 1'b0;
    ifc.data = 3'd3;
    ifc.load = 1'b1;
    tick();
    check("pre_rst_load3", ifc.count, 3'd3);
    ifc.load = 1'b0;
    ifc.stop = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("async_rst", ifc.count, 3'd0);
    ifc.stop = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rel_%0d", i), ifc.count,
            3'(rel_seq[i]));
    end

    // free-run from reset
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("run_%0d", i), ifc.count,
            3'(run_seq[i]));
      chk_tc($sformatf("run_tc_%0d", i),
             run_seq[i] == 0);
    end

    // load and clamp
    ifc.data = 3'd3;
    ifc.load = 1'b1;
    tick();
    check("load3", ifc.count, 3'd3);
    ifc.load = 1'b0;
    tick();
    check("ld_dec2", ifc.count, 3'd2);
    tick();
    check("ld_dec1", ifc.count, 3'd1);
    tick();
    check("ld_dec0", ifc.count, 3'd0);
    ifc.data = 3'd7;
    ifc.load = 1'b1;
    #1;
    chk_tc("tc_load_hi", 1'b0);
    tick();
    check("clamp7", ifc.count, 3'd5);
    ifc.data = 3'd1;
    tick();
    check("load1", ifc.count, 3'd1);
    ifc.data = 3'd6;
    tick();
    check("clamp6", ifc.count, 3'd5);

    // pause
    ifc.data = 3'd4;
    tick();
    check("load4", ifc.count, 3'd4);
    ifc.load = 1'b0;
    ifc.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_%0d", i), ifc.count, 3'd4);
      chk_tc($sformatf("hold_tc_%0d", i), 1'b0);
    end
    ifc.stop = 1'b1;
    tick();
    check("resume3", ifc.count, 3'd3);
    tick();
    check("resume2", ifc.count, 3'd2);
    ifc.data = 3'd0;
    ifc.load = 1'b1;
    tick();
    check("load0", ifc.count, 3'd0);
    ifc.load = 1'b0;
    ifc.stop = 1'b0;
    #1;
    chk_tc("tc_zero_paused", 1'b0);
    tick();
    check("hold_zero", ifc.count, 3'd0);
    ifc.stop = 1'b1;
    #1;
    chk_tc("tc_zero_run", 1'b1);

    // load beats decrement at zero
    ifc.data = 3'd2;
    ifc.load = 1'b1;
    #1;
    chk_tc("tc_prio_load", 1'b0);
    tick();
    check("prio_load2", ifc.count, 3'd2);

    // reset beats load
    ifc.data = 3'd4;
    reset    = 1'b1;
    #1;
    check("rst_vs_load", ifc.count, 3'd0);
    tick();
    check("rst_vs_load_edge", ifc.count, 3'd0);
    reset = 1'b0;

    // run past zero: wrap or saturate
    ifc.data = 3'd2;
    tick();
    check("load2", ifc.count, 3'd2);
    ifc.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("zero_%0d", i), ifc.count,
            3'(sat_seq[i]));
      chk_tc($sformatf("zero_tc_%0d", i),
             sat_tc[i] != 0);
    end
    ifc.data = 3'd4;
    ifc.load = 1'b1;
    tick();
    check("reload4", ifc.count, 3'd4);
    ifc.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
